// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   It executes MULTU/MULT (radix-2 shift-add) and DIVU/DIV (restoring
//   division on magnitudes), with one iteration per clock. It also accepts
//   mthi/mtlo writes while idle and always drives HI/LO for mfhi/mflo.
//
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   start, op, a, b     launch an operation (op: 00 MULTU, 01 MULT,
//                       10 DIVU, 11 DIV); sampled only while idle
//   hi_we, lo_we, wdata mthi/mtlo writes; honoured only while idle without start
//   busy                high while an operation is in flight
//   done                one-cycle pulse once HI/LO hold the new result
//   div_by_zero         pulses with done when a divide had b == 0
//   hi, lo              HI/LO registers
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic            is_div;      // latched op[1]
  logic            sign_q;      // product / quotient must be negated
  logic            sign_r;      // remainder takes the dividend's sign
  logic            b_zero;      // divide with a zero divisor
  logic [N-1:0]    a_raw;       // original dividend, returned in HI on divide by zero
  logic [N-1:0]    opnd;        // multiplicand (mult) or divisor (div) magnitude
  logic [2*N-1:0]  acc;         // {partial product | remainder, multiplier | quotient}

  logic [N:0]      mul_sum;
  logic [2*N-1:0]  mul_next;
  logic [N:0]      div_trial;
  logic [2*N-1:0]  div_next;
  logic [2*N-1:0]  prod_fix;
  logic [N-1:0]    quo_fix;
  logic [N-1:0]    rem_fix;
  logic            sgn_op;

  // Two's-complement magnitude of v when the operation is signed.
  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic is_signed);
    logic signed [N-1:0] sv;
    sv = $signed(v);
    if (is_signed && sv < 0)
      return N'(-sv);
    return v;
  endfunction

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic neg);
    return neg ? N'(-$signed(v)) : v;
  endfunction

  function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v, input logic neg);
    return neg ? (2*N)'(-$signed(v)) : v;
  endfunction

  assign busy   = (state != IDLE);
  assign sgn_op = op[0];

  // ---- FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == CW'(N - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- one iteration of each algorithm, and the final sign fix
  always_comb begin
    // shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one
    mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, opnd};
    mul_next  = acc[0] ? {mul_sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};
    // restoring divide: trial-subtract the divisor from the remainder with
    // the next dividend bit shifted in; keep the difference if non-negative
    div_trial = {acc[2*N-1:N], acc[N-1]} - {1'b0, opnd};
    div_next  = div_trial[N] ? {acc[2*N-2:0], 1'b0}
                             : {div_trial[N-1:0], acc[N-2:0], 1'b1};
    prod_fix  = neg_2n(acc, sign_q);
    quo_fix   = neg_n(acc[N-1:0], sign_q);
    rem_fix   = neg_n(acc[2*N-1:N], sign_r);
  end

  // ---- control
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      done        <= (state == FIN);
      div_by_zero <= (state == FIN) && b_zero;
      if (state == IDLE)
        count <= '0;
      else if (state == RUN)
        count <= count + CW'(1);
    end
  end

  // ---- operand latch, iteration, result write-back
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            sign_q <= sgn_op & (a[N-1] ^ b[N-1]);
            sign_r <= sgn_op & a[N-1];
            b_zero <= op[1] & (b == '0);
            a_raw  <= a;
            if (op[1]) begin
              opnd <= mag(b, sgn_op);
              acc  <= {{N{1'b0}}, mag(a, sgn_op)};
            end else begin
              opnd <= mag(a, sgn_op);
              acc  <= {{N{1'b0}}, mag(b, sgn_op)};
            end
          end else begin
            // start takes priority; mt writes in the same cycle are dropped
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: acc <= is_div ? div_next : mul_next;
        FIN: begin
          if (!is_div) begin
            hi <= prod_fix[2*N-1:N];
            lo <= prod_fix[N-1:0];
          end else if (b_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
